// File: rtl/par2ser_tx.sv
// par2ser_tx: byte-wide valid/ready input, small FIFO, continuous MSB-first
// serial output with one 8-clock byte slot per slot-counter wrap. Slots with
// nothing queued carry IDLE_BYTE so a free-running deserialiser stays aligned.
module par2ser_tx #(
  parameter int unsigned DEPTH     = 4,      // power of 2, >= 2
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               din,
  input  logic                     vldin,
  output logic                     rdy,
  output logic                     dout,
  output logic                     sof,
  output logic                     idle,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [2:0]       cnt;
  logic [6:0]       shreg;
  logic             slot_load;
  logic             push;
  logic             pop;
  logic [7:0]       slot_byte;

  // Occupancy after one edge; push and pop together leave it unchanged.
  function automatic logic [LVL_W-1:0] next_level(input logic [LVL_W-1:0] cur,
                                                   input logic push_i,
                                                   input logic pop_i);
    logic [LVL_W-1:0] nxt;
    nxt = cur;
    if (push_i && !pop_i) nxt = cur + LVL_W'(1);
    if (!push_i && pop_i) nxt = cur - LVL_W'(1);
    return nxt;
  endfunction

  // Handshake and slot decode from registered state only; rdy never depends on vldin,
  // and a pop at a full edge cannot be refilled in the same cycle.
  always_comb begin
    slot_load = (cnt == 3'd0);
    rdy       = (level != FULL_LVL);
    push      = vldin && rdy;
    pop       = slot_load && (level != '0);
    slot_byte = pop ? mem[rd_ptr] : IDLE_BYTE;
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers, occupancy and the free-running slot counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      cnt    <= 3'd0;
    end else begin
      cnt <= cnt + 3'd1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= next_level(level, push, pop);
    end
  end

  // Serialiser: load a whole byte at cnt==0 (bit 7 straight to dout), then shift left.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= 1'b0;
      shreg <= 7'd0;
      sof   <= 1'b0;
      idle  <= 1'b0;
    end else if (slot_load) begin
      dout  <= slot_byte[7];
      shreg <= slot_byte[6:0];
      sof   <= 1'b1;
      idle  <= !pop;
    end else begin
      dout  <= shreg[6];
      shreg <= {shreg[5:0], 1'b0};
      sof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_par2ser_tx.sv
// tb_par2ser_tx: two instances (IDLE_BYTE 00 and 7E) share one randomized
// source. Each lane has a queue-based reference model that pushes expected
// slot contents into a scoreboard; a monitor deserialises dout and compares.
module tb_par2ser_tx;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0] b;
    logic       idl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       vldin;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s lane%0d at %0t: got %0h expected %0h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam logic [7:0] IB = (g == 0) ? 8'h00 : 8'h7E;

    logic             rdy;
    logic             dout;
    logic             sof;
    logic             idle;
    logic [LVL_W-1:0] level;

    par2ser_tx #(.DEPTH(DEPTH), .IDLE_BYTE(IB)) dut (
      .clk(clk), .rst(rst), .din(din), .vldin(vldin),
      .rdy(rdy), .dout(dout), .sof(sof), .idle(idle), .level(level)
    );

    logic [7:0] mq[$];
    exp_t       eq[$];
    int  mcnt  = 0;
    int  mlvl  = 0;
    bit  m_acc = 1'b0;
    bit  m_sof = 1'b0;
    bit  m_rst = 1'b0;
    bit  seen  = 1'b0;

    // Reference model: byte slots every 8 clocks from reset release, queue of pending bytes.
    always @(posedge clk) begin : model
      int   pre;
      exp_t e;
      if (rst) begin
        mq.delete();
        eq.delete();
        mcnt  = 0;
        m_acc = 1'b0;
        m_sof = 1'b0;
        m_rst = 1'b1;
        seen  = 1'b1;
      end else begin
        pre   = mq.size();
        m_rst = 1'b0;
        m_acc = vldin && (pre != DEPTH);
        m_sof = (mcnt == 0);
        if (mcnt == 0) begin
          if (pre > 0) begin
            e.b   = mq.pop_front();
            e.idl = 1'b0;
          end else begin
            e.b   = IB;
            e.idl = 1'b1;
          end
          eq.push_back(e);
        end
        if (m_acc) mq.push_back(din);
        mcnt = (mcnt + 1) % 8;
      end
      mlvl = mq.size();
    end

    bit         active = 1'b0;
    int         nb     = 0;
    logic [7:0] acc    = 8'h00;
    exp_t       h;

    // Monitor: per-cycle control checks, and an 8-bit deserialiser started by sof.
    always @(negedge clk) begin : monitor
      if (seen) begin
        chk("rdy",   g, int'(rdy),   int'(mlvl != DEPTH));
        chk("level", g, int'(level), mlvl);
        chk("sof",   g, int'(sof),   int'(m_sof));
        if (m_rst) begin
          chk("rst_dout", g, int'(dout), 0);
          chk("rst_idle", g, int'(idle), 0);
          active = 1'b0;
        end else if (sof) begin
          active = 1'b1;
          nb     = 1;
          acc    = {7'd0, dout};
          if (eq.size() == 0) chk("exp_avail", g, 0, 1);
          else                chk("idle", g, int'(idle), int'(eq[0].idl));
        end else if (active) begin
          acc = {acc[6:0], dout};
          nb++;
          if (eq.size() == 0) chk("exp_avail", g, 0, 1);
          else                chk("idle", g, int'(idle), int'(eq[0].idl));
          if (nb == 8) begin
            active = 1'b0;
            if (eq.size() > 0) begin
              h = eq.pop_front();
              chk("byte", g, int'(acc), int'(h.b));
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the model reports it accepted.
  task automatic send(input logic [7:0] b);
    int n;
    vldin = 1'b1;
    din   = b;
    n     = 0;
    do begin
      step();
      n++;
    end while (!lane[0].m_acc && n < 200);
    if (!lane[0].m_acc) chk("send_timeout", 0, 0, 1);
    vldin = 1'b0;
  endtask

  // Wait until the next edge has slot counter c and the queue is empty.
  task automatic wait_slot(input int c);
    int n;
    n = 0;
    while (!(lane[0].mcnt == c && lane[0].mlvl == 0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("wait_timeout", 0, 0, 1);
  endtask

  initial begin
    logic [7:0] burst [5];
    burst = '{8'h81, 8'h3C, 8'hFF, 8'h00, 8'h5A};
    rst   = 1'b1;
    vldin = 1'b0;
    din   = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    repeat (24) step();

    wait_slot(7);
    send(8'hA5);
    repeat (16) step();

    wait_slot(1);
    for (int i = 0; i < 5; i++) send(burst[i]);
    repeat (48) step();

    wait_slot(0);
    send(8'hC3);
    repeat (24) step();

    wait_slot(1);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (16) step();

    vldin = 1'b1;
    din   = 8'($urandom);
    for (int i = 0; i < 80; i++) begin
      step();
      if (lane[0].m_acc) din = 8'($urandom);
    end
    vldin = 1'b0;

    for (int i = 0; i < 600; i++) begin
      if (!vldin || lane[0].m_acc) begin
        vldin = ($urandom_range(0, 2) != 0);
        din   = 8'($urandom);
      end
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst   = 1'b0;
    vldin = 1'b0;
    repeat (48) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/par2ser_tx.md
Name: par2ser_tx

Overview:
- Transmit-side parallel-to-serial stage. Accepts bytes over a valid/ready handshake into a small FIFO and shifts them out MSB-first on a 1-bit line.
- The line runs continuously: one byte slot every 8 clocks, starting at reset release.
- Sits directly upstream of the team's 8-bit serial-to-parallel deserialiser. That deserialiser has no framing and counts 8 bits from its own reset.
- Byte alignment is defined by the slot counter and marked by `sof`. If the deserialiser's reset is released 1 cycle after this block's, its 8-bit windows coincide with this block's slots.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of 2, ≥2.
- IDLE_BYTE, 8'h00, byte transmitted in any slot where the FIFO is empty.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  8  byte to transmit.
- vldin  input  1  din valid.
- rdy  output  1  block can accept a byte this cycle.
- dout  output  1  serial data, MSB first, registered.
- sof  output  1  high for the cycle in which dout carries bit 7 of a slot.
- idle  output  1  high for all 8 cycles of a slot carrying IDLE_BYTE.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied; level=0.
  - Slot counter cnt=0; shift register=0.
  - dout=0, sof=0, idle=0.
  - rdy=1 from the cycle after reset.
  - Reset mid-byte discards the in-flight byte and all queued bytes; no partial byte resumes.
- Handshake:
  - Push occurs at a posedge with vldin && rdy.
  - rdy = (level != DEPTH), decoded from registered state only. It has no combinational path from vldin.
  - din is captured at the push edge only.
  - vldin with rdy=0 is ignored; the source must hold din until accepted.
- Slot counter: cnt runs 0..7 and wraps to 0 at every posedge while rst=0.
- At a posedge with cnt==0 (slot load):
  - If level>0: pop head byte B, then dout<=B[7], shreg<=B[6:0], idle<=0.
  - If level==0: B=IDLE_BYTE, dout<=IDLE_BYTE[7], shreg<=IDLE_BYTE[6:0], idle<=1.
  - sof<=1.
- At a posedge with cnt!=0: dout<=shreg[6], shreg<=shreg<<1, sof<=0, idle holds its value.
- Latency:
  - First posedge after reset release is a slot load.
  - A byte pushed at edge t is emitted at the first slot-load edge strictly after t.
  - Minimum latency is 1 clock (push at edge with cnt==7).
  - Maximum latency is 8 clocks plus 8 for each byte queued ahead of it.
- No bypass: push and slot load at the same edge with level==0 sends IDLE_BYTE. The pushed byte goes into the next slot; level becomes 1.
- Simultaneous push and pop at one edge: level unchanged; FIFO order preserved.
- Full: rdy=0 and no push.
  - A pop at that edge lowers level to DEPTH-1.
  - rdy rises the following cycle; there is no same-cycle refill.
- FIFO pointers wrap modulo DEPTH; level is never >DEPTH and never <0.
- Steady-state throughput: 1 byte per 8 clocks. The source may push at any rate; backpressure is via rdy.

Test Plan:
- Reset release, vldin=0 for 24 clocks → dout=0 throughout (IDLE_BYTE=00); sof high at cycles 1, 9, 17 after release; idle=1; level=0; rdy=1.
- Push 8'hA5 at edge with cnt==7 → next 8 dout bits 1,0,1,0,0,1,0,1 starting at the following edge; sof on first bit; idle=0; level returns to 0.
- Push 8'h81, 8'h3C, 8'hFF, 8'h00, 8'h5A back-to-back from empty with DEPTH=4 → rdy drops when level=4. Bytes are emitted in order with no gaps. The downstream deserialiser, released 1 cycle later, outputs 81, 3C, FF, 00, 5A on consecutive valid pulses.
- Push coinciding with a slot load while empty (din=8'hC3) → that slot sends IDLE_BYTE with idle=1; the next slot sends C3.
- Assert rst for 1 cycle at cnt==4 mid-byte with 3 bytes queued → dout=0, level=0, sof=0 after the reset edge. The next posedge is a slot load of IDLE_BYTE; no queued byte appears.
- IDLE_BYTE=8'h7E, FIFO full, vldin held high with new data → rdy=0 holds the data; byte accepted exactly at the edge after the next pop; no byte is lost or duplicated.
